// File: rtl/td4_ctrl_seq_if.sv
// rtl/td4_ctrl_seq_if.sv - fetch handshake, datapath strobes and status of the TD4 sequencer
interface td4_ctrl_seq_if #(
    parameter int IMM_W = 4
);
    logic               imem_req;
    logic               imem_ack;
    logic [IMM_W+3:0]   imem_data;
    logic               alu_carry;
    logic [IMM_W-1:0]   imm;
    logic [1:0]         select;
    logic [3:0]         load;
    logic               pc_inc;
    logic               c_flag;
    logic               fault;
    logic               halted;

    modport master (
        output imem_req, imm, select, load, pc_inc, c_flag, fault, halted,
        input  imem_ack, imem_data, alu_carry
    );

    modport slave (
        input  imem_req, imm, select, load, pc_inc, c_flag, fault, halted,
        output imem_ack, imem_data, alu_carry
    );
endinterface

// File: rtl/td4_ctrl_seq.sv
// rtl/td4_ctrl_seq.sv - fetch/decode/exec control sequencer for the TD4-class CPU
// Optional HALT opcode (1101) is enabled by defining TD4_HALT_EN.
module td4_ctrl_seq #(
    parameter int IMM_W    = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic            clk_i,
    input  logic            n_reset_i,
    td4_ctrl_seq_if.master  bus
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
`ifdef TD4_HALT_EN
        ST_HALT   = 3'd4,
`endif
        ST_FAULT  = 3'd3
    } state_t;

    // Last counter value at which an ACK is still accepted; a miss here times out.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t             state_q, state_d;
    logic [IMM_W+3:0]   ir_q, ir_d;
    logic [7:0]         wait_q, wait_d;
    logic [1:0]         select_q, select_d;
    logic [3:0]         load_q, load_d;
    logic               pc_inc_q, pc_inc_d;
    logic               c_flag_q, c_flag_d;
    logic [3:0]         op;

    assign op = ir_q[IMM_W+3:IMM_W];

    // State and datapath-control registers; reset drops any strobe still pending.
    always_ff @(posedge clk_i) begin
        if (!n_reset_i) begin
            state_q  <= ST_FETCH;
            ir_q     <= '0;
            wait_q   <= '0;
            select_q <= '0;
            load_q   <= '0;
            pc_inc_q <= 1'b0;
            c_flag_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            wait_q   <= wait_d;
            select_q <= select_d;
            load_q   <= load_d;
            pc_inc_q <= pc_inc_d;
            c_flag_q <= c_flag_d;
        end
    end

    // Next state plus next strobes; strobes default low so each lasts one cycle.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        wait_d   = wait_q;
        select_d = select_q;
        load_d   = '0;
        pc_inc_d = 1'b0;
        c_flag_d = c_flag_q;

        case (state_q)
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    // ACK wins even on the cycle that would otherwise time out
                    ir_d    = bus.imem_data;
                    wait_d  = '0;
                    state_d = ST_DECODE;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q == WAIT_LAST) begin
                        state_d = ST_FAULT;
                    end
                end
            end

            ST_DECODE: begin
                // A-mux select stays put until the next decode
                select_d = {op[1], op[0] | op[3]};
                state_d  = ST_EXEC;
            end

            ST_EXEC: begin
                state_d  = ST_FETCH;
                // only the two ADD forms keep the adder carry
                c_flag_d = ((op == 4'b0000) || (op == 4'b0101)) ? bus.alu_carry : 1'b0;
                case (op)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011: load_d = 4'b0001;
                    4'b0100, 4'b0101, 4'b0110, 4'b0111: load_d = 4'b0010;
                    4'b1001, 4'b1011:                   load_d = 4'b0100;
                    // JNC looks at the flag from before this instruction
                    4'b1110:                            load_d = c_flag_q ? 4'b0000 : 4'b1000;
                    4'b1111:                            load_d = 4'b1000;
                    default:                            load_d = 4'b0000;
                endcase
                // exactly one strobe per instruction: PC advance only when nothing is written
                pc_inc_d = ~|load_d;
`ifdef TD4_HALT_EN
                if (op == 4'b1101) begin
                    state_d  = ST_HALT;
                    c_flag_d = c_flag_q;
                    pc_inc_d = 1'b0;
                end
`endif
            end

            ST_FAULT: begin
                state_d = ST_FAULT;
            end

`ifdef TD4_HALT_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Request is dropped while reset is held so nothing is fetched before release.
    assign bus.imem_req = (state_q == ST_FETCH) && n_reset_i;
    assign bus.imm      = ir_q[IMM_W-1:0];
    assign bus.select   = select_q;
    assign bus.load     = load_q;
    assign bus.pc_inc   = pc_inc_q;
    assign bus.c_flag   = c_flag_q;
    assign bus.fault    = (state_q == ST_FAULT);
`ifdef TD4_HALT_EN
    assign bus.halted   = (state_q == ST_HALT);
`else
    assign bus.halted   = 1'b0;
`endif

endmodule
